matvec_mac_seq: RTL and testbench

//  Column-serial signed matrix-vector multiplier: y = K*x with R rows, C columns.

---
 rtl/matvec_mac_seq.sv | 143 ++++++++++++++
 tb/tb_matvec_mac_seq.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matvec_mac_seq.sv
// Column-serial signed matrix-vector multiplier y = K*x, P columns per beat,
// with valid/ready handshakes on both sides and an optional per-vector ReLU.
module matvec_mac_seq #(
    parameter int R   = 8,
    parameter int C   = 8,
    parameter int W_X = 8,
    parameter int W_K = 8,
    parameter int P   = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  cen,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    input  logic [R*C*W_K-1:0]                    kf,
    input  logic [C*W_X-1:0]                      xf,
    input  logic                                  relu,
    output logic                                  m_valid,
    input  logic                                  m_ready,
    output logic [R*(W_X+W_K+$clog2(C))-1:0]      yf,
    output logic                                  busy
);

    localparam int BEATS = C / P;
    localparam int W_M   = W_X + W_K;
    localparam int W_Y   = W_M + $clog2(C);
    localparam int W_CNT = (BEATS > 1) ? $clog2(BEATS) : 1;

    if (P < 1 || P > C) begin : g_bad_p_range
        $error("matvec_mac_seq: P must lie in 1..C");
    end else if (C % P != 0) begin : g_bad_p_div
        $error("matvec_mac_seq: C must be a multiple of P");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                  state;
    state_t                  state_nx;
    logic [R*C*W_K-1:0]      k_q;
    logic [C*W_X-1:0]        x_q;
    logic                    relu_q;
    logic signed [W_Y-1:0]   acc      [R];
    logic signed [W_Y-1:0]   beat_sum [R];
    logic [W_CNT-1:0]        cnt;
    logic                    last;
    logic                    load;
    logic                    step;

    assign s_ready = (state == IDLE) && cen;
    assign m_valid = (state == DONE);
    assign busy    = (state != IDLE);
    assign last    = (cnt == W_CNT'(BEATS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state already folds in cen, so the state register needs no enable.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        case (state)
            IDLE: begin
                if (s_valid && s_ready) begin
                    load     = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (cen) begin
                    step = 1'b1;
                    if (last) begin
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                if (m_ready && cen) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Products are sign-extended to the accumulator width before summing.
    always_comb begin
        for (int unsigned r = 0; r < R; r++) begin
            beat_sum[r] = '0;
            for (int unsigned p = 0; p < P; p++) begin
                beat_sum[r] = beat_sum[r] + W_Y'(
                    W_M'($signed(k_q[(r*C + cnt*P + p)*W_K +: W_K])) *
                    W_M'($signed(x_q[(cnt*P + p)*W_X +: W_X])));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q    <= '0;
            x_q    <= '0;
            relu_q <= 1'b0;
            cnt    <= '0;
            for (int unsigned r = 0; r < R; r++) begin
                acc[r] <= '0;
            end
        end else if (load) begin
            k_q    <= kf;
            x_q    <= xf;
            relu_q <= relu;
            cnt    <= '0;
            for (int unsigned r = 0; r < R; r++) begin
                acc[r] <= '0;
            end
        end else if (step) begin
            cnt <= last ? '0 : cnt + W_CNT'(1);
            for (int unsigned r = 0; r < R; r++) begin
                acc[r] <= acc[r] + beat_sum[r];
            end
        end
    end

    always_comb begin
        yf = '0;
        if (state == DONE) begin
            for (int unsigned r = 0; r < R; r++) begin
                if (!(relu_q && acc[r][W_Y-1])) begin
                    yf[r*W_Y +: W_Y] = acc[r];
                end
            end
        end
    end

endmodule

// File: tb/tb_matvec_mac_seq.sv
// Self-checking bench: one small 2x4 instance plus four 8x8 instances (P=1,2,4,8)
// compared against a plain-arithmetic matrix-vector reference.
module tb_matvec_mac_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cen = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    int kk [8][8];
    int xx [8];
    int ym [8];
    int yo [8];

    // Small instance: R=2, C=4, P=2, W_Y=18
    logic        a_s_valid = 1'b0;
    logic        a_s_ready;
    logic [63:0] a_kf = '0;
    logic [31:0] a_xf = '0;
    logic        a_relu = 1'b0;
    logic        a_m_valid;
    logic        a_m_ready = 1'b0;
    logic [35:0] a_yf;
    logic        a_busy;

    matvec_mac_seq #(.R(2), .C(4), .W_X(8), .W_K(8), .P(2)) u_a (
        .clk(clk), .rst(rst), .cen(cen),
        .s_valid(a_s_valid), .s_ready(a_s_ready),
        .kf(a_kf), .xf(a_xf), .relu(a_relu),
        .m_valid(a_m_valid), .m_ready(a_m_ready),
        .yf(a_yf), .busy(a_busy)
    );

    // Large instances: R=8, C=8, P=1<<g, W_Y=19
    logic         s_valid_b [4];
    logic         s_ready_b [4];
    logic         m_valid_b [4];
    logic         m_ready_b [4];
    logic         busy_b    [4];
    logic [151:0] yf_b      [4];
    logic [511:0] kf_b = '0;
    logic [63:0]  xf_b = '0;
    logic         relu_b = 1'b0;

    for (genvar g = 0; g < 4; g++) begin : g_big
        matvec_mac_seq #(.R(8), .C(8), .W_X(8), .W_K(8), .P(1 << g)) u_b (
            .clk(clk), .rst(rst), .cen(cen),
            .s_valid(s_valid_b[g]), .s_ready(s_ready_b[g]),
            .kf(kf_b), .xf(xf_b), .relu(relu_b),
            .m_valid(m_valid_b[g]), .m_ready(m_ready_b[g]),
            .yf(yf_b[g]), .busy(busy_b[g])
        );
    end

    task automatic model(input int rows, input int cols, input bit rl);
        for (int r = 0; r < rows; r++) begin
            int s = 0;
            for (int c = 0; c < cols; c++) s += kk[r][c] * xx[c];
            ym[r] = (rl && s < 0) ? 0 : s;
        end
    endtask

    task automatic randomize_ops();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) kk[r][c] = int'($urandom_range(255)) - 128;
        for (int c = 0; c < 8; c++) xx[c] = int'($urandom_range(255)) - 128;
    endtask

    task automatic read_a();
        logic signed [17:0] t;
        for (int r = 0; r < 2; r++) begin
            t = a_yf[r*18 +: 18];
            yo[r] = t;
        end
    endtask

    task automatic read_b(input int idx);
        logic [151:0]       v;
        logic signed [18:0] t;
        v = yf_b[idx];
        for (int r = 0; r < 8; r++) begin
            t = v[r*19 +: 19];
            yo[r] = t;
        end
    endtask

    task automatic send_a(input bit rl);
        int tries = 0;
        @(negedge clk);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++) a_kf[(r*4 + c)*8 +: 8] = 8'(kk[r][c]);
        for (int c = 0; c < 4; c++) a_xf[c*8 +: 8] = 8'(xx[c]);
        a_relu    = rl;
        a_s_valid = 1'b1;
        while (!a_s_ready && tries < 50) begin
            @(negedge clk);
            tries++;
        end
        if (!a_s_ready) begin
            n_cmp++; n_err++;
            $display("FAIL send_a: s_ready got 0 required 1");
        end
        @(posedge clk);
        #1 a_s_valid = 1'b0;
        a_kf = '1;
        a_xf = '1;
    endtask

    task automatic wait_a(output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            if (cen) lat++;
            #1;
            if (a_m_valid) begin
                ok = 1'b1;
                break;
            end
        end
        read_a();
    endtask

    task automatic pop_a();
        @(negedge clk);
        a_m_ready = 1'b1;
        @(posedge clk);
        #1 a_m_ready = 1'b0;
    endtask

    task automatic send_b(input int idx, input bit rl);
        int tries = 0;
        @(negedge clk);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) kf_b[(r*8 + c)*8 +: 8] = 8'(kk[r][c]);
        for (int c = 0; c < 8; c++) xf_b[c*8 +: 8] = 8'(xx[c]);
        relu_b         = rl;
        s_valid_b[idx] = 1'b1;
        while (!s_ready_b[idx] && tries < 50) begin
            @(negedge clk);
            tries++;
        end
        if (!s_ready_b[idx]) begin
            n_cmp++; n_err++;
            $display("FAIL send_b: s_ready got 0 required 1");
        end
        @(posedge clk);
        #1 s_valid_b[idx] = 1'b0;
        kf_b   = {16{32'($urandom)}};
        xf_b   = {2{32'($urandom)}};
        relu_b = ~rl;
    endtask

    task automatic wait_b(input int idx, input bit toggle, output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (toggle) begin
                @(negedge clk);
                cen = ~cen;
            end
            @(posedge clk);
            if (cen) lat++;
            #1;
            if (m_valid_b[idx]) begin
                ok = 1'b1;
                break;
            end
        end
        cen = 1'b1;
        read_b(idx);
    endtask

    task automatic pop_b(input int idx);
        @(negedge clk);
        m_ready_b[idx] = 1'b1;
        @(posedge clk);
        #1 m_ready_b[idx] = 1'b0;
    endtask

    task automatic check_rows(input string name, input int rows);
        for (int r = 0; r < rows; r++) begin
            n_cmp++;
            if (yo[r] !== ym[r]) begin
                n_err++;
                $display("FAIL %s row %0d: got %0d required %0d", name, r, yo[r], ym[r]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (a_m_valid !== 1'b0 || a_busy !== 1'b0 || a_yf !== '0) begin
            n_err++;
            $display("FAIL reset_a: m_valid=%b busy=%b yf=%h required 0/0/0", a_m_valid, a_busy, a_yf);
        end
        for (int g = 0; g < 4; g++) begin
            n_cmp++;
            if (m_valid_b[g] !== 1'b0 || busy_b[g] !== 1'b0 || yf_b[g] !== '0) begin
                n_err++;
                $display("FAIL reset_b%0d: m_valid=%b busy=%b yf=%h required 0/0/0", g, m_valid_b[g], busy_b[g], yf_b[g]);
            end
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (a_s_ready !== 1'b1 || s_ready_b[0] !== 1'b1) begin
            n_err++;
            $display("FAIL reset_sready: got %b/%b required 1/1", a_s_ready, s_ready_b[0]);
        end
    endtask

    task automatic load_small();
        for (int c = 0; c < 4; c++) begin
            kk[0][c] = c + 1;
            kk[1][c] = -(c + 1);
            xx[c]    = 1;
        end
    endtask

    task automatic test_basic();
        int lat; bit ok;
        load_small();
        send_a(1'b0);
        wait_a(lat, ok);
        n_cmp++;
        if (!ok || lat !== 2) begin
            n_err++;
            $display("FAIL basic_latency: got %0d (valid=%b) required 2", lat, ok);
        end
        n_cmp++;
        if (yo[0] !== 10 || yo[1] !== -10) begin
            n_err++;
            $display("FAIL basic_y: got %0d,%0d required 10,-10", yo[0], yo[1]);
        end
        model(2, 4, 1'b0);
        check_rows("basic_model", 2);
        pop_a();
        n_cmp++;
        if (a_m_valid !== 1'b0 || a_busy !== 1'b0) begin
            n_err++;
            $display("FAIL basic_pop: m_valid=%b busy=%b required 0/0", a_m_valid, a_busy);
        end
    endtask

    task automatic test_relu();
        int lat; bit ok;
        load_small();
        send_a(1'b1);
        wait_a(lat, ok);
        n_cmp++;
        if (!ok || yo[0] !== 10 || yo[1] !== 0) begin
            n_err++;
            $display("FAIL relu_on: got %0d,%0d required 10,0", yo[0], yo[1]);
        end
        pop_a();
        send_a(1'b0);
        wait_a(lat, ok);
        n_cmp++;
        if (!ok || yo[0] !== 10 || yo[1] !== -10) begin
            n_err++;
            $display("FAIL relu_off: got %0d,%0d required 10,-10", yo[0], yo[1]);
        end
        pop_a();
    endtask

    task automatic test_extremes();
        int lat; bit ok;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) kk[r][c] = -128;
        for (int c = 0; c < 8; c++) xx[c] = -128;
        send_b(1, 1'b0);
        wait_b(1, 1'b0, lat, ok);
        for (int r = 0; r < 8; r++) ym[r] = 131072;
        check_rows("extreme_pos", 8);
        pop_b(1);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) kk[r][c] = 127;
        send_b(1, 1'b0);
        wait_b(1, 1'b0, lat, ok);
        for (int r = 0; r < 8; r++) ym[r] = -130048;
        check_rows("extreme_neg", 8);
        pop_b(1);
    endtask

    task automatic test_backpressure();
        int lat; bit ok;
        logic [151:0] held;
        randomize_ops();
        model(8, 8, 1'b0);
        send_b(1, 1'b0);
        wait_b(1, 1'b0, lat, ok);
        held = yf_b[1];
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            kf_b = {16{32'($urandom)}};
            s_valid_b[1] = 1'b1;
            @(posedge clk);
            #1;
            n_cmp++;
            if (yf_b[1] !== held || m_valid_b[1] !== 1'b1 || s_ready_b[1] !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold: yf=%h m_valid=%b s_ready=%b required yf=%h 1/0", yf_b[1], m_valid_b[1], s_ready_b[1], held);
            end
        end
        s_valid_b[1] = 1'b0;
        check_rows("bp_result", 8);
        pop_b(1);
        n_cmp++;
        if (m_valid_b[1] !== 1'b0 || busy_b[1] !== 1'b0 || s_ready_b[1] !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release: m_valid=%b busy=%b s_ready=%b required 0/0/1", m_valid_b[1], busy_b[1], s_ready_b[1]);
        end
        randomize_ops();
        model(8, 8, 1'b1);
        send_b(1, 1'b1);
        wait_b(1, 1'b0, lat, ok);
        check_rows("bp_next", 8);
        pop_b(1);
    endtask

    task automatic test_cen();
        int lat; bit ok;
        randomize_ops();
        model(8, 8, 1'b0);
        send_b(0, 1'b0);
        wait_b(0, 1'b1, lat, ok);
        n_cmp++;
        if (!ok || lat !== 8) begin
            n_err++;
            $display("FAIL cen_latency: got %0d active edges (valid=%b) required 8", lat, ok);
        end
        check_rows("cen_result", 8);
        pop_b(0);
    endtask

    task automatic test_random();
        int lat; bit ok; int idx; bit rl;
        for (int i = 0; i < 200; i++) begin
            idx = int'($urandom_range(3));
            rl  = 1'($urandom_range(1));
            randomize_ops();
            model(8, 8, rl);
            send_b(idx, rl);
            wait_b(idx, 1'b0, lat, ok);
            n_cmp++;
            if (!ok || lat !== (8 >> idx)) begin
                n_err++;
                $display("FAIL rand_latency P=%0d: got %0d required %0d", 1 << idx, lat, 8 >> idx);
            end
            check_rows("rand_y", 8);
            pop_b(idx);
        end
    endtask

    task automatic test_rst_mid_run();
        int lat; bit ok;
        randomize_ops();
        send_b(0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (m_valid_b[0] !== 1'b0 || busy_b[0] !== 1'b0 || yf_b[0] !== '0) begin
            n_err++;
            $display("FAIL rst_mid: m_valid=%b busy=%b yf=%h required 0/0/0", m_valid_b[0], busy_b[0], yf_b[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (s_ready_b[0] !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_sready: got %b required 1", s_ready_b[0]);
        end
        randomize_ops();
        model(8, 8, 1'b0);
        send_b(0, 1'b0);
        wait_b(0, 1'b0, lat, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL rst_mid_timeout: m_valid got 0 required 1");
        end
        check_rows("rst_mid_fresh", 8);
        pop_b(0);
    endtask

    initial begin
        for (int g = 0; g < 4; g++) begin
            s_valid_b[g] = 1'b0;
            m_ready_b[g] = 1'b0;
        end
        test_reset();
        test_basic();
        test_relu();
        test_extremes();
        test_backpressure();
        test_cen();
        test_rst_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
